// File: rtl/gbdt_max_seq.sv
// Round-wise argmax sequencer: fetches 8-score rounds from the score buffer, drives the
// external max unit with the running maximum, and publishes the predicted class/score.
module gbdt_max_seq #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic             gbdt_clk,
   input  logic             gbdt_rst,
   input  logic             start,
   input  logic [1:0]       num_rounds,
   output logic             score_req,
   output logic [1:0]       score_round,
   input  logic             score_valid,
   input  logic [7:0][31:0] score_data,
   output logic             max_enable,
   output logic [1:0]       round,
   output logic [7:0][31:0] results,
   output logic [31:0]      old_max_result,
   output logic [4:0]       old_max_class,
   input  logic             max_done,
   input  logic [31:0]      new_max_result,
   input  logic [4:0]       new_max_class,
   output logic             busy,
   output logic             pred_valid,
   output logic [4:0]       pred_class,
   output logic [31:0]      pred_score,
   output logic             timeout_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_CMP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

   state_t           r_state;
   state_t           w_state_nxt;

   logic             r_score_req;
   logic             r_max_enable;
   logic             r_busy;
   logic             r_timeout_err;
   logic             r_pred_valid;
   logic [1:0]       r_rnd;
   logic [1:0]       r_last_rnd;
   logic [7:0]       r_cnt;
   logic [1:0]       r_round;
   logic [7:0][31:0] r_results;
   logic [31:0]      r_old_max_result;
   logic [4:0]       r_old_max_class;
   logic [4:0]       r_pred_class;
   logic [31:0]      r_pred_score;

   logic             w_accept;
   logic             w_take;
   logic             w_cmp_hit;
   logic             w_timeout;
   logic             w_last;
   logic [7:0]       w_cnt_inc;

   assign w_last    = (r_rnd == r_last_rnd);
   assign w_cnt_inc = r_cnt + 8'd1;

   // Next-state decode and one-cycle event strobes for the register blocks below
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_take      = 1'b0;
      w_cmp_hit   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_REQ;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_REQ: begin
            if (score_valid) begin
               w_take      = 1'b1;
               w_state_nxt = S_CMP;
            end else begin
               w_state_nxt = S_REQ;
            end
         end
         S_CMP: begin
            if (max_done) begin
               w_cmp_hit   = 1'b1;
               w_state_nxt = w_last ? S_DONE : S_REQ;
            end else if (w_cnt_inc >= TO_LIMIT) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_CMP;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge gbdt_clk or posedge gbdt_rst) begin
      if (gbdt_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Handshake outputs, round bookkeeping, CMP watchdog and status flags
   always_ff @(posedge gbdt_clk or posedge gbdt_rst) begin
      if (gbdt_rst) begin
         r_score_req   <= 1'b0;
         r_max_enable  <= 1'b0;
         r_busy        <= 1'b0;
         r_timeout_err <= 1'b0;
         r_pred_valid  <= 1'b0;
         r_rnd         <= 2'd0;
         r_last_rnd    <= 2'd0;
         r_cnt         <= 8'd0;
      end else begin
         r_pred_valid <= (r_state == S_DONE);
         if (w_accept) begin
            r_last_rnd    <= num_rounds;
            r_rnd         <= 2'd0;
            r_score_req   <= 1'b1;
            r_busy        <= 1'b1;
            r_timeout_err <= 1'b0;
         end else if (w_take) begin
            r_score_req  <= 1'b0;
            r_max_enable <= 1'b1;
            r_cnt        <= 8'd0;
         end else if (w_cmp_hit) begin
            // Dropping enable here guarantees at least one low cycle before the next round
            r_max_enable <= 1'b0;
            if (!w_last) begin
               r_rnd       <= r_rnd + 2'd1;
               r_score_req <= 1'b1;
            end else begin
               r_rnd <= r_rnd;
            end
         end else if (w_timeout) begin
            r_max_enable  <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
         end else if (r_state == S_DONE) begin
            r_busy <= 1'b0;
         end else if (r_state == S_CMP) begin
            r_cnt <= w_cnt_inc;
         end else begin
            r_cnt <= r_cnt;
         end
      end
   end

   // Operands presented to the max unit; held steady for the whole compare
   always_ff @(posedge gbdt_clk or posedge gbdt_rst) begin
      if (gbdt_rst) begin
         r_round          <= 2'd0;
         r_results        <= '0;
         r_old_max_result <= 32'd0;
         r_old_max_class  <= 5'd0;
      end else if (w_accept) begin
         r_old_max_result <= 32'd0;
         r_old_max_class  <= 5'd0;
      end else if (w_take) begin
         r_results <= score_data;
         r_round   <= r_rnd;
      end else if (w_cmp_hit) begin
         r_old_max_result <= new_max_result;
         r_old_max_class  <= new_max_class;
      end else begin
         r_round <= r_round;
      end
   end

   // Prediction result, cleared by an accepted start and latched on completion
   always_ff @(posedge gbdt_clk or posedge gbdt_rst) begin
      if (gbdt_rst) begin
         r_pred_class <= 5'd0;
         r_pred_score <= 32'd0;
      end else if (w_accept) begin
         r_pred_class <= 5'd0;
         r_pred_score <= 32'd0;
      end else if (r_state == S_DONE) begin
         r_pred_class <= r_old_max_class;
         r_pred_score <= r_old_max_result;
      end else begin
         r_pred_class <= r_pred_class;
      end
   end

   assign score_req      = r_score_req;
   assign score_round    = r_rnd;
   assign max_enable     = r_max_enable;
   assign round          = r_round;
   assign results        = r_results;
   assign old_max_result = r_old_max_result;
   assign old_max_class  = r_old_max_class;
   assign busy           = r_busy;
   assign pred_valid     = r_pred_valid;
   assign pred_class     = r_pred_class;
   assign pred_score     = r_pred_score;
   assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_gbdt_max_seq.sv
// Bench for gbdt_max_seq: table of directed and random inferences checked against a flat
// argmax model, plus sequences for timeout and mid-run reset.
module tb_gbdt_max_seq;

   logic             gbdt_clk = 1'b0;
   logic             gbdt_rst;
   logic             start;
   logic [1:0]       num_rounds;
   logic             score_req;
   logic [1:0]       score_round;
   logic             score_valid;
   logic [7:0][31:0] score_data;
   logic             max_enable;
   logic [1:0]       round;
   logic [7:0][31:0] results;
   logic [31:0]      old_max_result;
   logic [4:0]       old_max_class;
   logic             max_done;
   logic [31:0]      new_max_result;
   logic [4:0]       new_max_class;
   logic             busy;
   logic             pred_valid;
   logic [4:0]       pred_class;
   logic [31:0]      pred_score;
   logic             timeout_err;

   gbdt_max_seq #(.TIMEOUT_CYCLES(15)) dut (
      .gbdt_clk(gbdt_clk), .gbdt_rst(gbdt_rst), .start(start), .num_rounds(num_rounds),
      .score_req(score_req), .score_round(score_round), .score_valid(score_valid),
      .score_data(score_data), .max_enable(max_enable), .round(round), .results(results),
      .old_max_result(old_max_result), .old_max_class(old_max_class), .max_done(max_done),
      .new_max_result(new_max_result), .new_max_class(new_max_class), .busy(busy),
      .pred_valid(pred_valid), .pred_class(pred_class), .pred_score(pred_score),
      .timeout_err(timeout_err)
   );

   always #5 gbdt_clk = ~gbdt_clk;

   // Score buffer: answers after a configurable delay in one chosen round
   logic [31:0][31:0] cur_scores;
   logic [1:0]        dly_rnd;
   int                dly;
   int                req_age;

   always @(posedge gbdt_clk) req_age <= score_req ? req_age + 1 : 0;

   always_comb begin
      score_data = '0;
      for (int i = 0; i < 8; i++) score_data[i] = cur_scores[{score_round, 3'(i)}];
   end
   assign score_valid = score_req && ((score_round != dly_rnd) || (req_age >= dly));

   // Max unit: done 2 cycles after enable rises, strict compare, can be silenced
   logic [1:0] mu_cnt;
   logic       mu_block;

   always @(posedge gbdt_clk) begin
      if (!max_enable) mu_cnt <= 2'd0;
      else if (mu_cnt != 2'd3) mu_cnt <= mu_cnt + 2'd1;
   end
   assign max_done = max_enable && (mu_cnt == 2'd2) && !mu_block;

   always_comb begin
      new_max_result = old_max_result;
      new_max_class  = old_max_class;
      for (int i = 0; i < 8; i++) begin
         if (results[i] > new_max_result) begin
            new_max_result = results[i];
            new_max_class  = {round, 3'(i)};
         end
      end
   end

   // Monitors: count enable rising edges and pred_valid cycles
   logic me_prev;
   int   me_rises;
   int   pv_cnt;
   always @(negedge gbdt_clk) begin
      me_prev <= max_enable;
      if (max_enable && !me_prev) me_rises <= me_rises + 1;
      if (pred_valid) pv_cnt <= pv_cnt + 1;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   typedef struct {
      logic [1:0]        nr;
      logic [31:0][31:0] sc;
      logic [4:0]        ecls;
      logic [31:0]       escr;
      int                poke;
      logic [1:0]        drnd;
      int                dcyc;
   } vec_t;

   vec_t tbl[16];

   // Reference: flat argmax over all used classes, strict >, starting from 0
   task automatic ref_argmax(input logic [1:0] nr, input logic [31:0][31:0] sc,
                             output logic [4:0] cls, output logic [31:0] scr);
      scr = 32'd0;
      cls = 5'd0;
      for (int c = 0; c < (int'(nr) + 1) * 8; c++) begin
         if (sc[c] > scr) begin
            scr = sc[c];
            cls = 5'(c);
         end
      end
   endtask

   task automatic run(input int idx);
      vec_t v;
      int   cyc;
      int   rises0;
      int   exp_lat;
      v          = tbl[idx];
      cur_scores = v.sc;
      dly_rnd    = v.drnd;
      dly        = v.dcyc;
      num_rounds = v.nr;
      rises0     = me_rises;
      exp_lat    = 1 + 4 * (int'(v.nr) + 1) + ((v.drnd <= v.nr) ? v.dcyc : 0);
      @(negedge gbdt_clk);
      start = 1'b1;
      @(posedge gbdt_clk);
      #1;
      start = 1'b0;
      chk($sformatf("v%0d_busy_on", idx), 64'(busy), 64'd1);
      chk($sformatf("v%0d_terr_clr", idx), 64'(timeout_err), 64'd0);
      cyc = 0;
      while (!pred_valid && cyc < 300) begin
         @(posedge gbdt_clk);
         #1;
         cyc++;
         start = (cyc == v.poke) ? 1'b1 : 1'b0;
      end
      start = 1'b0;
      chk($sformatf("v%0d_latency", idx), 64'(cyc), 64'(exp_lat));
      chk($sformatf("v%0d_class", idx), 64'(pred_class), 64'(v.ecls));
      chk($sformatf("v%0d_score", idx), 64'(pred_score), 64'(v.escr));
      @(posedge gbdt_clk);
      #1;
      chk($sformatf("v%0d_pulse", idx), 64'(pred_valid), 64'd0);
      chk($sformatf("v%0d_hold", idx), 64'(pred_class), 64'(v.ecls));
      chk($sformatf("v%0d_idle", idx), 64'(busy), 64'd0);
      chk($sformatf("v%0d_rounds", idx), 64'(me_rises - rises0), 64'(int'(v.nr) + 1));
   endtask

   initial begin
      int cyc;
      int pv0;
      gbdt_rst   = 1'b1;
      start      = 1'b0;
      num_rounds = 2'd0;
      cur_scores = '0;
      dly_rnd    = 2'd0;
      dly        = 0;
      mu_block   = 1'b0;
      me_rises   = 0;
      pv_cnt     = 0;

      // Directed vectors
      foreach (tbl[k]) begin
         tbl[k].nr = 2'd0; tbl[k].sc = '0; tbl[k].poke = 0; tbl[k].drnd = 2'd0; tbl[k].dcyc = 0;
         tbl[k].ecls = 5'd0; tbl[k].escr = 32'd0;
      end
      tbl[0].sc[0] = 32'd5; tbl[0].sc[1] = 32'd9; tbl[0].sc[2] = 32'd3; tbl[0].sc[3] = 32'd9;
      tbl[0].sc[4] = 32'd1; tbl[0].sc[5] = 32'd0; tbl[0].sc[6] = 32'd2; tbl[0].sc[7] = 32'd7;
      tbl[0].ecls = 5'd1; tbl[0].escr = 32'd9;
      tbl[1].nr = 2'd3;
      for (int c = 0; c < 32; c++) tbl[1].sc[c] = $urandom_range(0, 32'hfff);
      tbl[1].sc[20] = 32'h8000_0000;
      tbl[1].ecls = 5'd20; tbl[1].escr = 32'h8000_0000;
      tbl[2].nr = 2'd1;
      for (int c = 0; c < 16; c++) tbl[2].sc[c] = $urandom_range(0, 49);
      tbl[2].sc[6] = 32'd50; tbl[2].sc[11] = 32'd50;
      tbl[2].ecls = 5'd6; tbl[2].escr = 32'd50;
      tbl[3].nr = 2'd2; tbl[3].drnd = 2'd1; tbl[3].dcyc = 3; tbl[3].poke = 6;
      for (int c = 0; c < 24; c++) tbl[3].sc[c] = $urandom_range(0, 1000);
      ref_argmax(tbl[3].nr, tbl[3].sc, tbl[3].ecls, tbl[3].escr);
      tbl[4].poke = 4;
      tbl[5].nr = 2'd3;
      for (int c = 0; c < 32; c++) tbl[5].sc[c] = 32'd7;
      tbl[5].ecls = 5'd0; tbl[5].escr = 32'd7;
      // Random vectors
      for (int k = 6; k < 16; k++) begin
         tbl[k].nr   = 2'($urandom_range(0, 3));
         tbl[k].drnd = 2'($urandom_range(0, 3));
         tbl[k].dcyc = $urandom_range(0, 2);
         for (int c = 0; c < 32; c++) begin
            tbl[k].sc[c] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40);
         end
         ref_argmax(tbl[k].nr, tbl[k].sc, tbl[k].ecls, tbl[k].escr);
      end

      #12;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_pred_valid", 64'(pred_valid), 64'd0);
      chk("rst_max_enable", 64'(max_enable), 64'd0);
      chk("rst_score_req", 64'(score_req), 64'd0);
      chk("rst_timeout", 64'(timeout_err), 64'd0);
      chk("rst_pred", 64'({pred_class, pred_score}), 64'd0);
      @(negedge gbdt_clk);
      gbdt_rst = 1'b0;

      for (int k = 0; k < 16; k++) run(k);

      // Timeout: max unit never completes
      mu_block   = 1'b1;
      cur_scores = tbl[1].sc;
      num_rounds = 2'd1;
      dly        = 0;
      pv0        = pv_cnt;
      @(negedge gbdt_clk);
      start = 1'b1;
      @(posedge gbdt_clk);
      #1;
      start = 1'b0;
      cyc = 0;
      while (!max_enable && cyc < 50) begin
         @(posedge gbdt_clk);
         #1;
         cyc++;
      end
      cyc = 0;
      while (max_enable && cyc < 100) begin
         cyc++;
         @(posedge gbdt_clk);
         #1;
      end
      chk("to_enable_cycles", 64'(cyc), 64'd15);
      chk("to_err", 64'(timeout_err), 64'd1);
      chk("to_busy", 64'(busy), 64'd0);
      chk("to_score_req", 64'(score_req), 64'd0);
      repeat (3) @(posedge gbdt_clk);
      #1;
      chk("to_no_pred", 64'(pv_cnt - pv0), 64'd0);
      chk("to_err_sticky", 64'(timeout_err), 64'd1);
      mu_block = 1'b0;
      run(0);

      // Reset during CMP of round 1
      cur_scores = tbl[1].sc;
      num_rounds = 2'd2;
      dly        = 0;
      @(negedge gbdt_clk);
      start = 1'b1;
      @(posedge gbdt_clk);
      #1;
      start = 1'b0;
      cyc = 0;
      while (!(max_enable && round == 2'd1) && cyc < 100) begin
         @(posedge gbdt_clk);
         #1;
         cyc++;
      end
      chk("rr_reached_cmp1", 64'(max_enable && round == 2'd1), 64'd1);
      pv0 = pv_cnt;
      #2;
      gbdt_rst = 1'b1;
      #1;
      chk("rr_max_enable", 64'(max_enable), 64'd0);
      chk("rr_busy", 64'(busy), 64'd0);
      chk("rr_score_req", 64'(score_req), 64'd0);
      chk("rr_old_max", 64'({old_max_class, old_max_result}), 64'd0);
      @(negedge gbdt_clk);
      @(negedge gbdt_clk);
      gbdt_rst = 1'b0;
      repeat (6) @(posedge gbdt_clk);
      #1;
      chk("rr_no_pred", 64'(pv_cnt - pv0), 64'd0);
      run(1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
